// File: rtl/cipu_pkg.sv
// cipu_pkg: shared source ids, arbiter state encoding and CIPU producer character constants
package cipu_pkg;

    localparam logic [1:0] SRC_FIFO  = 2'd0;
    localparam logic [1:0] SRC_LIFO  = 2'd1;
    localparam logic [1:0] SRC_FIFO2 = 2'd2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } state_t;

    localparam logic [7:0] CH_DOLLAR = "$";
    localparam logic [7:0] CH_SEMI   = ";";
    localparam logic [7:0] CH_ZERO   = "0";

    function automatic logic [1:0] next_src(input logic [1:0] s);
        return (s == SRC_FIFO2) ? SRC_FIFO : s + 2'd1;
    endfunction

endpackage

// File: rtl/cipu_rr_pick.sv
// cipu_rr_pick: combinational 3-way winner select (starved first, then fixed or round-robin)
//   elig     eligible sources
//   starved  sources whose wait counter hit the limit
//   ptr      last winner (round-robin starts after it)
//   mode_rr  1 = round-robin, 0 = lowest index
//   win      winning source index, valid when found
//   found    at least one eligible source
module cipu_rr_pick
    import cipu_pkg::*;
(
    input  logic [2:0] elig,
    input  logic [2:0] starved,
    input  logic [1:0] ptr,
    input  logic       mode_rr,
    output logic [1:0] win,
    output logic       found
);
    logic [2:0] hot;
    logic [1:0] c1, c2, low, rr, st;

    assign hot   = elig & starved;
    assign c1    = next_src(ptr);
    assign c2    = next_src(c1);
    assign st    = hot[0] ? SRC_FIFO : hot[1] ? SRC_LIFO : SRC_FIFO2;
    assign low   = elig[0] ? SRC_FIFO : elig[1] ? SRC_LIFO : SRC_FIFO2;
    assign rr    = elig[c1] ? c1 : elig[c2] ? c2 : ptr;
    assign win   = |hot ? st : mode_rr ? rr : low;
    assign found = |elig;

endmodule

// File: rtl/cipu_out_arbiter.sv
// cipu_out_arbiter: packet scheduler sharing one registered output bus between three CIPU streams
//   clk, rst (async, active-low)
//   mode_rr       1 = round-robin, 0 = fixed priority, used only for IDLE decisions
//   session_clr   clears FIFO2 enable and pkt_count
//   lifo_done     arms FIFO2 eligibility
//   req_valid/req_data/req_last/req_ready   per-source beat port, src i at [i*DW +: DW]
//   out_valid/out_data/out_src/out_last/out_ready   registered downstream port
//   pkt_done      per-source pulse after a last beat leaves downstream
//   busy          packet in flight or output register occupied
//   pkt_count     packets delivered since reset or session_clr
module cipu_out_arbiter
    import cipu_pkg::*;
#(
    parameter int DW       = 8,
    parameter int MAX_WAIT = 15
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          mode_rr,
    input  logic          session_clr,
    input  logic          lifo_done,
    input  logic [2:0]    req_valid,
    input  logic [3*DW-1:0] req_data,
    input  logic [2:0]    req_last,
    output logic [2:0]    req_ready,
    input  logic          out_ready,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    output logic [1:0]    out_src,
    output logic          out_last,
    output logic [2:0]    pkt_done,
    output logic          busy,
    output logic [7:0]    pkt_count
);
    state_t     state, state_nx;
    logic [1:0] owner, rr_ptr, win;
    logic       found, grant, load, fire, xfer_ok, fifo2_en;
    logic [2:0] elig, starved;
    logic [7:0] wait_cnt [3];

    // FIFO2 may only drain once the LIFO session has reported done
    assign elig    = {req_valid[2] & fifo2_en, req_valid[1:0]};
    assign xfer_ok = !out_valid || out_ready;
    assign grant   = state == ST_IDLE && found;
    assign load    = state == ST_LOCK && req_valid[owner] && xfer_ok;
    assign fire    = out_valid && out_ready && out_last;
    assign busy    = state != ST_IDLE || out_valid;

    always_comb begin
        for (int i = 0; i < 3; i++) starved[i] = wait_cnt[i] == 8'(MAX_WAIT);
    end

    cipu_rr_pick u_pick (
        .elig    (elig),
        .starved (starved),
        .ptr     (rr_ptr),
        .mode_rr (mode_rr),
        .win     (win),
        .found   (found)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        req_ready = '0;
        if (state == ST_IDLE) begin
            state_nx = found ? ST_LOCK : ST_IDLE;
        end else begin
            req_ready = xfer_ok ? (3'b001 << owner) : 3'b000;
            state_nx  = (load && req_last[owner]) ? ST_IDLE : ST_LOCK;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner     <= SRC_FIFO;
            rr_ptr    <= SRC_FIFO2;
            fifo2_en  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= SRC_FIFO;
            out_last  <= 1'b0;
            pkt_done  <= '0;
            pkt_count <= '0;
        end else begin
            if (grant) begin
                owner  <= win;
                rr_ptr <= win;
            end
            // session_clr beats lifo_done, which beats the end-of-FIFO2-packet clear
            fifo2_en  <= session_clr ? 1'b0 : lifo_done ? 1'b1 :
                         (load && owner == SRC_FIFO2 && req_last[2]) ? 1'b0 : fifo2_en;
            out_valid <= load || (out_valid && !out_ready);
            if (load) begin
                out_data <= req_data[owner*DW +: DW];
                out_src  <= owner;
                out_last <= req_last[owner];
            end
            pkt_done  <= fire ? (3'b001 << out_src) : 3'b000;
            pkt_count <= session_clr ? 8'd0 : pkt_count + 8'(fire);
        end
    end

    // a source only accumulates wait while eligible and not holding the bus
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 3; i++) wait_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 3; i++)
                wait_cnt[i] <= (!elig[i] || (grant && win == 2'(i)) || (state == ST_LOCK && owner == 2'(i))) ? 8'd0 :
                               starved[i] ? wait_cnt[i] : wait_cnt[i] + 8'd1;
        end
    end

endmodule

// File: tb/tb_cipu_out_arbiter.sv
// tb_cipu_out_arbiter: directed stimulus with a per-cycle reference model and literal checkpoints
module tb_cipu_out_arbiter;
    localparam int DW = 8;
    localparam int MW = 15;

    typedef struct {
        logic [7:0] d;
        bit         l;
    } beat_t;

    typedef struct {
        int s;
        int d;
        bit l;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mode_rr = 1'b0;
    logic        session_clr = 1'b0;
    logic        lifo_done = 1'b0;
    logic [2:0]  req_valid = '0;
    logic [23:0] req_data = '0;
    logic [2:0]  req_last = '0;
    logic [2:0]  req_ready;
    logic        out_ready = 1'b0;
    logic        out_valid;
    logic [7:0]  out_data;
    logic [1:0]  out_src;
    logic        out_last;
    logic [2:0]  pkt_done;
    logic        busy;
    logic [7:0]  pkt_count;

    cipu_out_arbiter #(.DW(DW), .MAX_WAIT(MW)) dut (
        .clk         (clk),
        .rst         (rst),
        .mode_rr     (mode_rr),
        .session_clr (session_clr),
        .lifo_done   (lifo_done),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_last    (req_last),
        .req_ready   (req_ready),
        .out_ready   (out_ready),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_src     (out_src),
        .out_last    (out_last),
        .pkt_done    (pkt_done),
        .busy        (busy),
        .pkt_count   (pkt_count)
    );

    always #5 clk = ~clk;

    beat_t q [3][$];
    ev_t   log_q [$];
    int    pd_log [$];
    int    nvec = 0;
    int    nerr = 0;

    bit c_mode, c_ordy, c_sclr, c_ldone;

    bit       m_lock, m_f2, m_ov, m_ol;
    int       m_own, m_rr, m_od, m_os, m_pd, m_pc;
    int       m_wc [3];
    bit [2:0] m_rdy;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s t=%0t got=%0h expected=%0h", nm, $time, act, exp);
        end
    endtask

    function automatic int enc(input int s, input int d, input bit l);
        return (s << 9) | (d << 1) | int'(l);
    endfunction

    function automatic int ev_at(input int i);
        return (i < log_q.size()) ? enc(log_q[i].s, log_q[i].d, log_q[i].l) : -1;
    endfunction

    task automatic add_beat(input int s, input logic [7:0] d, input bit l);
        beat_t b;
        b.d = d;
        b.l = l;
        q[s].push_back(b);
    endtask

    task automatic add_pkt(input int s, input string str);
        for (int k = 0; k < str.len(); k++) add_beat(s, str[k], k == str.len() - 1);
    endtask

    task automatic model_reset();
        m_lock = 0; m_own = 0; m_rr = 2; m_f2 = 0;
        m_ov = 0; m_od = 0; m_os = 0; m_ol = 0; m_pd = 0; m_pc = 0;
        for (int i = 0; i < 3; i++) m_wc[i] = 0;
    endtask

    task automatic model_step();
        bit [2:0] el;
        int       win;
        bit       ld, fire;
        for (int i = 0; i < 3; i++) el[i] = req_valid[i] && (i < 2 || m_f2);
        win = -1;
        if (!m_lock) begin
            for (int i = 0; i < 3; i++) if (win < 0 && el[i] && m_wc[i] == MW) win = i;
            if (win < 0 && c_mode)
                for (int k = 1; k <= 3; k++) if (win < 0 && el[(m_rr + k) % 3]) win = (m_rr + k) % 3;
            if (win < 0 && !c_mode)
                for (int i = 0; i < 3; i++) if (win < 0 && el[i]) win = i;
        end
        ld   = m_lock && m_rdy[m_own] && req_valid[m_own];
        fire = m_ov && c_ordy && m_ol;
        for (int i = 0; i < 3; i++)
            m_wc[i] = (!el[i] || win == i || (m_lock && m_own == i)) ? 0 : (m_wc[i] < MW ? m_wc[i] + 1 : MW);
        m_pd = fire ? (1 << m_os) : 0;
        m_pc = c_sclr ? 0 : (m_pc + (fire ? 1 : 0)) % 256;
        if (c_sclr) m_f2 = 0;
        else if (c_ldone) m_f2 = 1;
        else if (ld && m_own == 2 && req_last[2]) m_f2 = 0;
        if (ld) begin
            m_od = int'(req_data[m_own*8 +: 8]);
            m_os = m_own;
            m_ol = req_last[m_own];
            void'(q[m_own].pop_front());
        end
        m_ov = ld || (m_ov && !c_ordy);
        if (ld && req_last[m_own]) m_lock = 0;
        if (win >= 0) begin
            m_lock = 1;
            m_own  = win;
            m_rr   = win;
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            req_valid[i]       = q[i].size() > 0;
            req_data[i*8 +: 8] = req_valid[i] ? q[i][0].d : 8'h00;
            req_last[i]        = req_valid[i] && q[i][0].l;
        end
        mode_rr     = c_mode;
        out_ready   = c_ordy;
        session_clr = c_sclr;
        lifo_done   = c_ldone;
        #1;
        m_rdy = (m_lock && (!m_ov || c_ordy)) ? 3'(1 << m_own) : 3'b000;
        chk("out_valid", out_valid, m_ov);
        if (m_ov) begin
            chk("out_data", out_data, m_od);
            chk("out_src", out_src, m_os);
            chk("out_last", out_last, m_ol);
        end
        chk("req_ready", req_ready, m_rdy);
        chk("pkt_done", pkt_done, m_pd);
        chk("pkt_count", pkt_count, m_pc);
        chk("busy", busy, m_lock || m_ov);
        if (out_valid && out_ready) log_q.push_back('{int'(out_src), int'(out_data), out_last});
        if (pkt_done != 0) pd_log.push_back(int'(pkt_done));
        model_step();
        c_sclr  = 0;
        c_ldone = 0;
    endtask

    task automatic run(input int n);
        repeat (n) cyc();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_data"}, out_data, 0);
        chk({tag, "_out_src"}, out_src, 0);
        chk({tag, "_out_last"}, out_last, 0);
        chk({tag, "_req_ready"}, req_ready, 0);
        chk({tag, "_pkt_done"}, pkt_done, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_pkt_count"}, pkt_count, 0);
    endtask

    initial begin
        int    base;
        string s3;
        model_reset();
        c_mode = 0; c_ordy = 1; c_sclr = 0; c_ldone = 0;
        #2;
        chk_reset_outputs("RST0");
        @(negedge clk);
        rst = 1'b1;

        // fixed priority: src0 "AB" then src1 "12"
        add_pkt(0, "AB");
        add_pkt(1, "12");
        run(12);
        chk("T1_n", log_q.size(), 4);
        chk("T1_e0", ev_at(0), enc(0, "A", 0));
        chk("T1_e1", ev_at(1), enc(0, "B", 1));
        chk("T1_e2", ev_at(2), enc(1, "1", 0));
        chk("T1_e3", ev_at(3), enc(1, "2", 1));
        chk("T1_pd_n", pd_log.size(), 2);
        chk("T1_pd0", pd_log.size() > 0 ? pd_log[0] : -1, 1);
        chk("T1_pd1", pd_log.size() > 1 ? pd_log[1] : -1, 2);
        chk("T1_cnt", pkt_count, 2);

        // FIFO2 gating until lifo_done
        base = log_q.size();
        add_pkt(2, "7");
        for (int k = 0; k < 20; k++) begin
            cyc();
            chk("T2_gate", req_ready[2], 0);
        end
        c_ldone = 1;
        cyc();
        run(6);
        chk("T2_n", log_q.size(), base + 1);
        chk("T2_e", ev_at(base), enc(2, "7", 1));
        chk("T2_cnt", pkt_count, 3);
        add_pkt(2, "8");
        for (int k = 0; k < 10; k++) begin
            cyc();
            chk("T2_reclosed", req_ready[2], 0);
        end
        q[2].delete();
        c_sclr = 1;
        cyc();
        cyc();
        chk("T2_clr", pkt_count, 0);

        // round-robin with FIFO2 kept armed
        base = log_q.size();
        c_mode = 1;
        s3 = "abcdef";
        for (int k = 0; k < 6; k++) add_beat(k % 3, s3[k], 1);
        for (int k = 0; k < 16; k++) begin
            c_ldone = 1;
            cyc();
        end
        run(4);
        for (int k = 0; k < 6; k++) chk("T3_rr", ev_at(base + k), enc(k % 3, s3[k], 1));

        // backpressure mid-packet
        c_mode = 0;
        base = log_q.size();
        add_pkt(0, "ABC");
        run(3);
        c_ordy = 0;
        for (int k = 0; k < 5; k++) begin
            cyc();
            chk("T4_hold", out_data, "B");
            chk("T4_rdy0", req_ready[0], 0);
        end
        c_ordy = 1;
        run(6);
        chk("T4_n", log_q.size(), base + 3);
        chk("T4_e0", ev_at(base), enc(0, "A", 0));
        chk("T4_e1", ev_at(base + 1), enc(0, "B", 0));
        chk("T4_e2", ev_at(base + 2), enc(0, "C", 1));

        // starvation guard under fixed priority
        base = log_q.size();
        for (int k = 0; k < 10; k++) add_beat(0, 8'h30 + 8'(k), 1);
        add_pkt(1, "Z");
        run(40);
        for (int k = 0; k < 8; k++) chk("T5_src0", ev_at(base + k), enc(0, 8'h30 + k, 1));
        chk("T5_starve", ev_at(base + 8), enc(1, "Z", 1));
        chk("T5_n", log_q.size(), base + 11);

        // asynchronous reset while a beat is held
        c_mode = 1;
        c_ordy = 0;
        add_pkt(0, "XYZ");
        run(3);
        chk("T6_pre_valid", out_valid, 1);
        #2;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) q[i].delete();
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        model_reset();
        #1;
        chk_reset_outputs("T6");
        @(negedge clk);
        rst = 1'b1;
        c_ordy = 1;
        base = log_q.size();
        add_pkt(0, "P");
        add_pkt(1, "Q");
        run(8);
        chk("T6_first", ev_at(base), enc(0, "P", 1));
        chk("T6_second", ev_at(base + 1), enc(1, "Q", 1));

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
